// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM host port between masters A and B
module sdram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wr_data,
    input  logic              a_wr_en,
    input  logic              a_rd_en,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rd_data,
    output logic              a_err,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wr_data,
    input  logic              b_wr_en,
    input  logic              b_rd_en,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rd_data,
    output logic              b_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic              ram_busy,
    input  logic              ram_rd_ready,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
    localparam logic [7:0] TMO = 8'(RD_TIMEOUT - 1);

    state_t            r_state, w_next;
    logic              r_owner, r_ptr, r_wr, r_err;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data, r_a_rd_data, r_b_rd_data;
    logic              w_a_req, w_b_req, w_pick, w_timeout, w_rd_done;
    logic [DATA_W-1:0] w_rd_val;

    assign w_a_req   = a_wr_en | a_rd_en;
    assign w_b_req   = b_wr_en | b_rd_en;
    assign w_pick    = (w_a_req & w_b_req) ? r_ptr : w_b_req;
    assign w_timeout = r_cnt == TMO;
    assign w_rd_done = r_state == WAIT_RD && (ram_rd_ready || w_timeout);
    assign w_rd_val  = ram_rd_ready ? ram_rd_data : '0;

    assign ram_addr    = r_addr;
    assign ram_wr_data = r_wr_data;
    assign ram_wr_en   = r_state == ISSUE && !ram_busy && r_wr;
    assign ram_rd_en   = r_state == ISSUE && !ram_busy && !r_wr;
    assign a_ack       = r_state == DONE && !r_owner;
    assign b_ack       = r_state == DONE && r_owner;
    assign a_err       = a_ack & r_err;
    assign b_err       = b_ack & r_err;
    assign a_rd_data   = r_a_rd_data;
    assign b_rd_data   = r_b_rd_data;
    assign owner       = r_owner;

    // state register
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    // next-state: grant, wait for a free downstream port, wait for read data, acknowledge
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_a_req | w_b_req) ? ISSUE : IDLE;
            ISSUE:   w_next = ram_busy ? ISSUE : (r_wr ? DONE : WAIT_RD);
            WAIT_RD: w_next = w_rd_done ? DONE : WAIT_RD;
            default: w_next = IDLE;
        endcase
    end

    // grant latch, timeout counter, read-data capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_a_rd_data <= '0;
            r_b_rd_data <= '0;
        end else begin
            if (r_state == IDLE && (w_a_req | w_b_req)) begin
                r_owner   <= w_pick;
                r_addr    <= w_pick ? b_addr : a_addr;
                r_wr_data <= w_pick ? b_wr_data : a_wr_data;
                r_wr      <= w_pick ? b_wr_en : a_wr_en;
                r_err     <= 1'b0;
            end
            if (r_state == ISSUE)
                r_cnt <= '0;
            if (r_state == WAIT_RD && !w_rd_done)
                r_cnt <= r_cnt + 8'd1;
            if (w_rd_done) begin
                r_err <= !ram_rd_ready;
                if (r_owner)
                    r_b_rd_data <= w_rd_val;
                else
                    r_a_rd_data <= w_rd_val;
            end
            if (r_state == DONE)
                r_ptr <= ~r_owner;
        end
    end
endmodule
